gpr_scoreboard: RTL and testbench

- Tracks GPR writes that decode has issued downstream but writeback has not yet retired.
- Generalises decode's single `exu_rd` compare to a multi-entry RAW hazard check, so several writers can be in flight at once.
- Sits between IDU (issue and query side) and the WBU/GPR write port (retire side), and produces the IDU stall and issue-permit signals.

---
 rtl/gpr_scoreboard.sv | 95 +++++++++
 tb/tb_gpr_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: counts GPR writes issued by decode but not yet retired by
// writeback, flags RAW hazards on the current IDU sources and gates issue
// when the per-register or total in-flight capacity is exhausted.
module gpr_scoreboard #(
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                issue_valid,
    input  logic [4:0]                          issue_rd,
    output logic                                issue_ok,
    input  logic                                wb_valid,
    input  logic [4:0]                          wb_rd,
    input  logic [4:0]                          rs1,
    input  logic                                need_rs1,
    input  logic [4:0]                          rs2,
    input  logic                                need_rs2,
    output logic                                raw,
    output logic [31:0]                         busy,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                                err
);

    localparam int unsigned TOT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [TOT_W-1:0] TOT_MAX = TOT_W'(MAX_INFLIGHT);

    // cnt[0] is never incremented because issue_rd==0 never counts
    logic [CNT_W-1:0] cnt [32];
    logic [TOT_W-1:0] total;
    logic             err_q;

    logic issue_eff;
    logic wb_eff;
    logic err_set;
    logic same_reg;

    // Issue permit, effective issue/retire and error conditions from registered counts
    always_comb begin
        issue_ok  = (total < TOT_MAX) && ((issue_rd == 5'd0) || (cnt[issue_rd] != '1));
        issue_eff = issue_valid && issue_ok && (issue_rd != 5'd0);
        wb_eff    = wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] != '0);
        same_reg  = issue_eff && wb_eff && (issue_rd == wb_rd);
        err_set   = (issue_valid && !issue_ok)
                 || (wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] == '0));
    end

    // Hazard and status outputs; no writeback bypass, a retire clears raw one cycle later
    always_comb begin
        raw = (need_rs1 && (rs1 != 5'd0) && (cnt[rs1] != '0))
           || (need_rs2 && (rs2 != 5'd0) && (cnt[rs2] != '0));
        busy = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            busy[i] = (cnt[i] != '0);
        end
        inflight = total;
        err      = err_q;
    end

    // Counter and sticky error state; flush overrides same-cycle issue/retire but keeps err
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            total <= '0;
            err_q <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (flush) begin
                for (int unsigned i = 0; i < 32; i++) begin
                    cnt[i] <= '0;
                end
                total <= '0;
            end else begin
                // issue and retire on the same register cancel, leaving that counter alone
                if (issue_eff && !same_reg) begin
                    cnt[issue_rd] <= cnt[issue_rd] + CNT_W'(1);
                end
                if (wb_eff && !same_reg) begin
                    cnt[wb_rd] <= cnt[wb_rd] - CNT_W'(1);
                end
                if (issue_eff && !wb_eff) begin
                    total <= total + TOT_W'(1);
                end else if (wb_eff && !issue_eff) begin
                    total <= total - TOT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gpr_scoreboard.sv
// tb_gpr_scoreboard: directed scenarios followed by random traffic, all
// outputs compared every cycle against an array-of-counts reference model.
module tb_gpr_scoreboard;

    localparam int unsigned CNT_W        = 2;
    localparam int unsigned MAX_INFLIGHT = 4;
    localparam int unsigned CNT_MAX      = (1 << CNT_W) - 1;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ok;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [4:0]  rs1;
    logic        need_rs1;
    logic [4:0]  rs2;
    logic        need_rs2;
    logic        raw;
    logic [31:0] busy;
    logic [2:0]  inflight;
    logic        err;

    int checks = 0;
    int errors = 0;

    int unsigned m_cnt [32];
    bit          m_err;

    gpr_scoreboard #(
        .CNT_W        (CNT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ok    (issue_ok),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .rs1         (rs1),
        .need_rs1    (need_rs1),
        .rs2         (rs2),
        .need_rs2    (need_rs2),
        .raw         (raw),
        .busy        (busy),
        .inflight    (inflight),
        .err         (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int unsigned m_total();
        int unsigned s = 0;
        for (int i = 0; i < 32; i++) s += m_cnt[i];
        return s;
    endfunction

    function automatic bit m_issue_ok();
        return (m_total() < MAX_INFLIGHT) && ((issue_rd == 0) || (m_cnt[issue_rd] != CNT_MAX));
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] e_busy;
        bit          e_raw;
        e_busy = '0;
        for (int i = 1; i < 32; i++) e_busy[i] = (m_cnt[i] != 0);
        e_raw = (need_rs1 && rs1 != 0 && m_cnt[rs1] != 0) || (need_rs2 && rs2 != 0 && m_cnt[rs2] != 0);
        cmp("issue_ok", 32'(issue_ok), 32'(m_issue_ok()));
        cmp("raw", 32'(raw), 32'(e_raw));
        cmp("busy", busy, e_busy);
        cmp("inflight", 32'(inflight), m_total());
        cmp("err", 32'(err), 32'(m_err));
    endtask

    // Advance one edge and move the model by the rules, using pre-edge state
    task automatic tick();
        bit ok, iss, ret;
        @(posedge clock);
        ok  = m_issue_ok();
        iss = issue_valid && ok && issue_rd != 0;
        ret = wb_valid && wb_rd != 0 && m_cnt[wb_rd] != 0;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_err = 0;
        end else begin
            if (issue_valid && !ok) m_err = 1;
            if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_err = 1;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            end else begin
                if (iss) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
                if (ret) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
            end
        end
        @(negedge clock);
    endtask

    task automatic apply(input logic iv, input logic [4:0] ird, input logic wv, input logic [4:0] wrd,
                         input logic [4:0] r1, input logic n1, input logic [4:0] r2, input logic n2,
                         input logic fl);
        issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_rd = wrd;
        rs1 = r1; need_rs1 = n1; rs2 = r2; need_rs2 = n2; flush = fl;
        #1;
        check_model();
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0;
        rs1 = 0; need_rs1 = 0; rs2 = 0; need_rs2 = 0; flush = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        do_reset();

        // reset state
        idle();
        cmp("rst_busy", busy, 32'h0);
        cmp("rst_inflight", 32'(inflight), 0);
        cmp("rst_raw", 32'(raw), 0);
        cmp("rst_issue_ok", 32'(issue_ok), 1);
        cmp("rst_err", 32'(err), 0);
        tick();

        // single writer to x5, retire, raw clears a cycle later
        apply(1, 5, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 5, 1, 0, 0, 0); cmp("raw5_set", 32'(raw), 1); tick();
        apply(0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
        apply(0, 0, 1, 5, 5, 1, 0, 0, 0); cmp("raw5_nobypass", 32'(raw), 1); tick();
        apply(0, 0, 0, 0, 5, 1, 0, 0, 0); cmp("raw5_clr", 32'(raw), 0); cmp("busy5_clr", 32'(busy[5]), 0); tick();

        // two writers to x7
        apply(1, 7, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 7, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 0, 1, 7, 0, 0, 7, 1, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 7, 1, 0); cmp("raw7_one_left", 32'(raw), 1); cmp("inflight7", 32'(inflight), 1); tick();
        apply(0, 0, 1, 7, 0, 0, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 7, 1, 0); cmp("raw7_clr", 32'(raw), 0); tick();

        // same-cycle issue and retire on x3
        apply(1, 3, 0, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 3, 1, 3, 0, 0, 0, 0, 0); tick();
        idle(); cmp("busy3_net0", 32'(busy[3]), 1); cmp("inflight_net0", 32'(inflight), 1); tick();
        apply(0, 0, 1, 3, 0, 0, 0, 0, 0); tick();

        // fill total capacity, then an issue while blocked
        for (int r = 1; r <= 4; r++) begin
            apply(1, 5'(r), 0, 0, 0, 0, 0, 0, 0); tick();
        end
        apply(0, 9, 0, 0, 0, 0, 0, 0, 0); cmp("full_inflight", 32'(inflight), 4); cmp("full_issue_ok", 32'(issue_ok), 0); tick();
        apply(1, 9, 0, 0, 0, 0, 0, 0, 0); tick();
        idle(); cmp("blocked_inflight", 32'(inflight), 4); cmp("blocked_busy9", 32'(busy[9]), 0); cmp("blocked_err", 32'(err), 1); tick();

        // per-register saturation on x6 (max 3)
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply(1, 6, 0, 0, 0, 0, 0, 0, 0); tick();
        end
        apply(0, 6, 0, 0, 0, 0, 0, 0, 0); cmp("sat6_issue_ok", 32'(issue_ok), 0); tick();
        apply(0, 8, 0, 0, 0, 0, 0, 0, 0); cmp("sat6_other_ok", 32'(issue_ok), 1); tick();

        // rd=0 issue, flush, then a stale retire
        do_reset();
        for (int r = 1; r <= 3; r++) begin
            apply(1, 5'(r), 0, 0, 0, 0, 0, 0, 0); tick();
        end
        apply(1, 0, 0, 0, 0, 1, 0, 0, 0); cmp("rs0_raw", 32'(raw), 0); tick();
        idle(); cmp("rd0_inflight", 32'(inflight), 3); tick();
        apply(1, 4, 1, 1, 0, 0, 0, 0, 1); tick();
        idle(); cmp("flush_inflight", 32'(inflight), 0); cmp("flush_busy", busy, 32'h0); cmp("flush_err", 32'(err), 0); tick();
        apply(0, 0, 1, 2, 0, 0, 0, 0, 0); tick();
        idle(); cmp("stale_err", 32'(err), 1); cmp("stale_inflight", 32'(inflight), 0); tick();

        // random traffic on a small register window to force collisions
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (n % 150 == 149) begin
                do_reset();
            end
            apply(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 29) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
